mem_port_arbiter: RTL and testbench

//  Shares the single-ported main memory between two CPU requesters: port 0 (instruction fetch)
//  and port 1 (load/store). Sits between cpu and mem inside top. Arbitrates round-robin,

---
 rtl/mem_port_arbiter_if.sv | 20 ++
 rtl/mem_port_arbiter.sv | 101 ++++++++++
 tb/tb_mem_port_arbiter.sv | 281 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_port_arbiter_if.sv
// mem_port_arbiter_if: one requester port (request and response) of the memory port arbiter
interface mem_port_arbiter_if;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] addr;
  logic        we;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  modport master (
    output req_valid, addr, we, wdata, wstrb,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );
  modport slave (
    input  req_valid, addr, we, wdata, wstrb,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: round-robin sharing of one single-ported memory between fetch (m0) and load/store (m1)
module mem_port_arbiter #(
  parameter int MEM_BYTES   = 65536,
  parameter int MEM_LATENCY = 1
) (
  input  logic                clock,
  input  logic                reset,
  mem_port_arbiter_if.slave   m0,
  mem_port_arbiter_if.slave   m1,
  output logic                mem_en,
  output logic                mem_we,
  output logic [31:0]         mem_addr,
  output logic [31:0]         mem_wdata,
  output logic [3:0]          mem_wstrb,
  input  logic [31:0]         mem_rdata,
  output logic                busy
);
  localparam int CW = $clog2(MEM_LATENCY + 1);
  typedef enum logic [1:0] {IDLE, ACCESS, WAIT, RESP} state_t;
  state_t           state;
  logic             owner, last_grant, we_l;
  logic [CW-1:0]    cnt;
  logic [1:0]       rsp_valid, rsp_err;
  logic [1:0][31:0] rsp_rdata;
  logic             grant, accept, in_range;
  logic [31:0]      sel_addr;
  // Grant the only valid port, or alternate away from the last winner when both ask
  always_comb begin
    grant    = (m0.req_valid & m1.req_valid) ? ~last_grant : m1.req_valid;
    sel_addr = grant ? m1.addr : m0.addr;
    accept   = (state == IDLE) & (grant ? m1.req_valid : m0.req_valid);
    in_range = {1'b0, sel_addr} < 33'(MEM_BYTES);
  end
  assign m0.req_ready = reset & (state == IDLE) & ~grant;
  assign m1.req_ready = reset & (state == IDLE) & grant;
  assign m0.rsp_valid = rsp_valid[0];
  assign m1.rsp_valid = rsp_valid[1];
  assign m0.rsp_err   = rsp_err[0];
  assign m1.rsp_err   = rsp_err[1];
  assign m0.rsp_rdata = rsp_rdata[0];
  assign m1.rsp_rdata = rsp_rdata[1];
  assign busy         = state != IDLE;
  // Transaction sequencer: mem strobe and response are one-cycle registered pulses
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      owner      <= 1'b0;
      last_grant <= 1'b1;
      we_l       <= 1'b0;
      cnt        <= '0;
      mem_en     <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      mem_wstrb  <= '0;
      rsp_valid  <= '0;
      rsp_err    <= '0;
      rsp_rdata  <= '0;
    end else begin
      mem_en    <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_wstrb <= '0;
      rsp_valid <= '0;
      rsp_err   <= '0;
      rsp_rdata <= '0;
      case (state)
        IDLE: if (accept) begin
          owner      <= grant;
          last_grant <= grant;
          we_l       <= grant ? m1.we : m0.we;
          if (in_range) begin
            state     <= ACCESS;
            mem_en    <= 1'b1;
            mem_we    <= grant ? m1.we : m0.we;
            mem_addr  <= {sel_addr[31:2], 2'b00};
            mem_wdata <= grant ? m1.wdata : m0.wdata;
            mem_wstrb <= grant ? m1.wstrb : m0.wstrb;
          end else begin
            state            <= RESP;
            rsp_valid[grant] <= 1'b1;
            rsp_err[grant]   <= 1'b1;
          end
        end
        ACCESS: begin
          state <= WAIT;
          cnt   <= '0;
        end
        WAIT: if (cnt == CW'(MEM_LATENCY - 1)) begin
          state            <= RESP;
          rsp_valid[owner] <= 1'b1;
          rsp_rdata[owner] <= we_l ? 32'h0 : mem_rdata;
        end else begin
          cnt <= cnt + 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: checks two arbiters (latency 1 and 3) against a transaction-timeline model
module tb_mem_port_arbiter;
  localparam int MEM_BYTES = 65536;
  localparam int WORDS = MEM_BYTES / 4;
  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;
  logic        rv [2][2], rdy [2][2], rwe [2][2], rsv [2][2], rse [2][2];
  logic [31:0] raddr [2][2], rwd [2][2], rsd [2][2];
  logic [3:0]  rws [2][2];
  logic        men [2], mwe [2], bsy [2];
  logic [31:0] maddr [2], mwd [2], mrd [2];
  logic [3:0]  mws [2];
  logic [31:0] mem [2][WORDS];
  logic [31:0] pipe [2][3];
  int errors, checks, cyc;
  int idle_at [2], mem_at [2], rsp_at [2], acc_edge [2], men_cnt [2], busy_cnt [2], gn [2];
  int gs [2][8];
  int last_rsp_edge [2][2];
  logic [31:0] last_rsp_data [2][2];
  logic        last_rsp_err [2][2];
  logic        own [2], lastg [2], e_we [2], e_err [2];
  logic [31:0] e_addr [2], e_wd [2], e_rd [2];
  logic [3:0]  e_ws [2];
  for (genvar g = 0; g < 2; g++) begin : inst
    mem_port_arbiter_if pa ();
    mem_port_arbiter_if pb ();
    assign pa.req_valid = rv[g][0];
    assign pa.addr      = raddr[g][0];
    assign pa.we        = rwe[g][0];
    assign pa.wdata     = rwd[g][0];
    assign pa.wstrb     = rws[g][0];
    assign pb.req_valid = rv[g][1];
    assign pb.addr      = raddr[g][1];
    assign pb.we        = rwe[g][1];
    assign pb.wdata     = rwd[g][1];
    assign pb.wstrb     = rws[g][1];
    assign rdy[g][0] = pa.req_ready;
    assign rsv[g][0] = pa.rsp_valid;
    assign rsd[g][0] = pa.rsp_rdata;
    assign rse[g][0] = pa.rsp_err;
    assign rdy[g][1] = pb.req_ready;
    assign rsv[g][1] = pb.rsp_valid;
    assign rsd[g][1] = pb.rsp_rdata;
    assign rse[g][1] = pb.rsp_err;
    assign mrd[g] = pipe[g][g ? 2 : 0];
    mem_port_arbiter #(.MEM_BYTES(MEM_BYTES), .MEM_LATENCY(g ? 3 : 1)) dut (
      .clock(clock), .reset(reset), .m0(pa.slave), .m1(pb.slave),
      .mem_en(men[g]), .mem_we(mwe[g]), .mem_addr(maddr[g]), .mem_wdata(mwd[g]),
      .mem_wstrb(mws[g]), .mem_rdata(mrd[g]), .busy(bsy[g])
    );
  end
  function automatic int lat(input int i);
    return i ? 3 : 1;
  endfunction
  task automatic chk(input string tag, input logic [79:0] obs, input logic [79:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic check_zero(input int i, input string tag);
    chk($sformatf("%s ready i%0d", tag, i), 80'({rdy[i][1], rdy[i][0]}), 80'(0));
    chk($sformatf("%s mem i%0d", tag, i), 80'({men[i], mwe[i], maddr[i], mwd[i], mws[i]}), 80'(0));
    chk($sformatf("%s rsp i%0d", tag, i), 80'({rsv[i][1], rse[i][1], rsd[i][1], rsv[i][0], rse[i][0], rsd[i][0]}), 80'(0));
    chk($sformatf("%s busy i%0d", tag, i), 80'(bsy[i]), 80'(0));
  endtask
  task automatic check_inst(input int i, output int accp);
    int c;
    logic busy_e, g, acc;
    c = cyc;
    busy_e = c < idle_at[i];
    g = (rv[i][0] && rv[i][1]) ? ~lastg[i] : rv[i][1];
    acc = !busy_e && rv[i][g];
    accp = acc ? int'(g) : -1;
    chk($sformatf("busy i%0d c%0d", i, c), 80'(bsy[i]), 80'(busy_e));
    if (rv[i][0] || rv[i][1])
      chk($sformatf("ready i%0d c%0d", i, c), 80'({rdy[i][1], rdy[i][0]}), 80'({acc && g, acc && !g}));
    chk($sformatf("mem i%0d c%0d", i, c), 80'({men[i], mwe[i], maddr[i], mwd[i], mws[i]}),
        c == mem_at[i] ? 80'({1'b1, e_we[i], e_addr[i][31:2], 2'b00, e_wd[i], e_ws[i]}) : 80'(0));
    for (int p = 0; p < 2; p++) begin
      chk($sformatf("rsp i%0d p%0d c%0d", i, p, c), 80'({rsv[i][p], rse[i][p], rsd[i][p]}),
          (c == rsp_at[i] && int'(own[i]) == p) ? 80'({1'b1, e_err[i], e_rd[i]}) : 80'(0));
      if (rsv[i][p]) begin
        last_rsp_edge[i][p] = c + 1;
        last_rsp_data[i][p] = rsd[i][p];
        last_rsp_err[i][p]  = rse[i][p];
      end
    end
    if (men[i]) men_cnt[i]++;
    if (bsy[i]) busy_cnt[i]++;
    if (acc) begin
      acc_edge[i] = c + 1;
      if (gn[i] < 8) gs[i][gn[i]] = int'(g);
      gn[i]++;
      own[i] = g;
      lastg[i] = g;
      e_we[i] = rwe[i][g];
      e_addr[i] = raddr[i][g];
      e_wd[i] = rwd[i][g];
      e_ws[i] = rws[i][g];
      if (longint'(raddr[i][g]) < MEM_BYTES) begin
        mem_at[i] = c + 1;
        rsp_at[i] = c + 2 + lat(i);
        idle_at[i] = c + 3 + lat(i);
        e_err[i] = 1'b0;
        e_rd[i] = rwe[i][g] ? 32'h0 : mem[i][raddr[i][g][15:2]];
      end else begin
        mem_at[i] = -1;
        rsp_at[i] = c + 1;
        idle_at[i] = c + 2;
        e_err[i] = 1'b1;
        e_rd[i] = 32'h0;
      end
    end
  endtask
  task automatic step();
    int accp [2];
    int idx [2];
    logic wr [2];
    logic [31:0] rd [2], wd [2];
    logic [3:0] ws [2];
    @(negedge clock);
    for (int i = 0; i < 2; i++) begin
      check_inst(i, accp[i]);
      idx[i] = int'(maddr[i][15:2]);
      wr[i] = men[i] & mwe[i];
      wd[i] = mwd[i];
      ws[i] = mws[i];
      rd[i] = (men[i] && !mwe[i]) ? mem[i][idx[i]] : $urandom;
    end
    @(posedge clock);
    cyc++;
    #1;
    for (int i = 0; i < 2; i++) begin
      if (accp[i] >= 0) rv[i][accp[i]] = 1'b0;
      pipe[i][2] = pipe[i][1];
      pipe[i][1] = pipe[i][0];
      pipe[i][0] = rd[i];
      if (wr[i])
        for (int b = 0; b < 4; b++)
          if (ws[i][b]) mem[i][idx[i]][b*8 +: 8] = wd[i][b*8 +: 8];
    end
  endtask
  task automatic set_req(input int i, input int p, input logic [31:0] a, input logic w,
                         input logic [31:0] d, input logic [3:0] s);
    rv[i][p] = 1'b1;
    raddr[i][p] = a;
    rwe[i][p] = w;
    rwd[i][p] = d;
    rws[i][p] = s;
  endtask
  task automatic txn(input string tag, input int p, input logic [31:0] a, input logic w,
                     input logic [31:0] d, input logic [3:0] s, input int n);
    for (int i = 0; i < 2; i++) begin
      set_req(i, p, a, w, d, s);
      men_cnt[i] = 0;
      busy_cnt[i] = 0;
      last_rsp_edge[i][p] = -1;
      last_rsp_data[i][p] = 'x;
      last_rsp_err[i][p] = 1'bx;
    end
    repeat (n) step();
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("%s accepted i%0d", tag, i), 80'(rv[i][p]), 80'(0));
      rv[i][p] = 1'b0;
    end
  endtask
  task automatic reset_pulse();
    reset = 1'b0;
    #1;
    for (int i = 0; i < 2; i++) begin
      check_zero(i, "midreset");
      idle_at[i] = cyc;
      mem_at[i] = -1;
      rsp_at[i] = -1;
      lastg[i] = 1'b1;
    end
    #1 reset = 1'b1;
  endtask
  task automatic new_req(input int i, input int p);
    logic [31:0] a;
    case ($urandom_range(0, 7))
      0: a = MEM_BYTES - 4;
      1: a = MEM_BYTES;
      2: a = 32'hFFFF_FFFC;
      3: a = $urandom;
      default: a = $urandom_range(0, MEM_BYTES - 1);
    endcase
    set_req(i, p, a, 1'($urandom_range(0, 1)), $urandom, 4'($urandom));
  endtask
  initial begin
    logic [31:0] old [2];
    errors = 0;
    checks = 0;
    cyc = 0;
    for (int i = 0; i < 2; i++) begin
      for (int w = 0; w < WORDS; w++) mem[i][w] = $urandom;
      mem[i][4] = 32'hDEAD_BEEF;
      for (int k = 0; k < 3; k++) pipe[i][k] = 32'h0;
      idle_at[i] = 0;
      mem_at[i] = -1;
      rsp_at[i] = -1;
      lastg[i] = 1'b1;
      own[i] = 1'b0;
      gn[i] = 0;
      set_req(i, 0, 32'h10, 1'b0, $urandom, 4'hF);
      set_req(i, 1, 32'h40, 1'b0, $urandom, 4'hF);
    end
    reset = 1'b1;
    #1 reset = 1'b0;
    #2;
    for (int i = 0; i < 2; i++) check_zero(i, "reset");
    @(posedge clock);
    #1 reset = 1'b1;
    for (int k = 0; k < 60; k++) begin
      step();
      for (int i = 0; i < 2; i++)
        for (int p = 0; p < 2; p++)
          if (!rv[i][p] && gn[i] < 4) rv[i][p] = 1'b1;
    end
    for (int i = 0; i < 2; i++) begin
      rv[i][0] = 1'b0;
      rv[i][1] = 1'b0;
      chk($sformatf("alt count i%0d", i), 80'(gn[i] >= 4), 80'(1));
      for (int k = 0; k < 4; k++) chk($sformatf("alt grant i%0d k%0d", i, k), 80'(gs[i][k]), 80'(k % 2));
    end
    txn("read10", 0, 32'h10, 1'b0, 32'h1234_5678, 4'hF, 10);
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("read10 latency i%0d", i), 80'(last_rsp_edge[i][0] - acc_edge[i]), 80'(i ? 5 : 3));
      chk($sformatf("read10 data i%0d", i), 80'({last_rsp_err[i][0], last_rsp_data[i][0]}), 80'({1'b0, 32'hDEAD_BEEF}));
      chk($sformatf("read10 busy cycles i%0d", i), 80'(busy_cnt[i]), 80'(i ? 5 : 3));
    end
    for (int i = 0; i < 2; i++) old[i] = mem[i][8];
    txn("write20", 1, 32'h20, 1'b1, 32'hA5A5_A5A5, 4'b0011, 10);
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("write20 mem_en count i%0d", i), 80'(men_cnt[i]), 80'(1));
      chk($sformatf("write20 rsp i%0d", i), 80'({last_rsp_err[i][1], last_rsp_data[i][1]}), 80'(0));
      chk($sformatf("write20 word i%0d", i), 80'(mem[i][8]), 80'({old[i][31:16], 16'hA5A5}));
    end
    txn("oob", 1, MEM_BYTES, 1'b0, 32'h0, 4'hF, 8);
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("oob latency i%0d", i), 80'(last_rsp_edge[i][1] - acc_edge[i]), 80'(1));
      chk($sformatf("oob rsp i%0d", i), 80'({last_rsp_err[i][1], last_rsp_data[i][1]}), 80'({1'b1, 32'h0}));
      chk($sformatf("oob mem_en count i%0d", i), 80'(men_cnt[i]), 80'(0));
    end
    txn("top word", 0, MEM_BYTES - 4, 1'b0, 32'h0, 4'hF, 10);
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("top word err i%0d", i), 80'(last_rsp_err[i][0]), 80'(0));
      chk($sformatf("top word data i%0d", i), 80'(last_rsp_data[i][0]), 80'(mem[i][WORDS-1]));
    end
    txn("max addr", 0, 32'hFFFF_FFFC, 1'b0, 32'h0, 4'hF, 8);
    for (int i = 0; i < 2; i++) chk($sformatf("max addr err i%0d", i), 80'(last_rsp_err[i][0]), 80'(1));
    for (int i = 0; i < 2; i++) set_req(i, 0, 32'h10, 1'b0, 32'h0, 4'hF);
    for (int k = 0; k < 10 && rv[0][0]; k++) step();
    chk("midreset accepted", 80'(rv[0][0]), 80'(0));
    step();
    for (int i = 0; i < 2; i++) begin
      set_req(i, 0, 32'h40, 1'b0, 32'h0, 4'hF);
      set_req(i, 1, 32'h10, 1'b0, 32'h0, 4'hF);
      gn[i] = 0;
    end
    reset_pulse();
    repeat (16) step();
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("after reset first grant i%0d", i), 80'({gn[i] >= 1, gs[i][0]}), 80'({1'b1, 32'd0}));
      rv[i][0] = 1'b0;
      rv[i][1] = 1'b0;
    end
    repeat (500) begin
      step();
      for (int i = 0; i < 2; i++)
        for (int p = 0; p < 2; p++)
          if (!rv[i][p] && $urandom_range(0, 2) == 0) new_req(i, p);
    end
    repeat (30) step();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
